// File: rtl/mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_pkg                                                                    |
// | Mode encodings and select-width helper shared by the N:1 mux slice.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mux_pkg;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Channel-index width; never narrower than one bit.
    function automatic int calc_sw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter                                                                 |
// | Rotating-priority arbiter: first requester after ptr, wrapping modulo N.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);

    // Scan from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt                         = '0;
                gnt[(int'(ptr) + k) % N]    = 1'b1;
                gnt_idx                     = SW'((int'(ptr) + k) % N);
                gnt_any                     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_rr_nx1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_rr_nx1                                                                 |
// | N:1 registered mux with valid/ready, static or round-robin selection.      |
// | Optional packet hold (in_last + lock) when MUX_HOLD_EN is defined.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mux_rr_nx1
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = calc_sw(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
`ifdef MUX_HOLD_EN
    input  logic [N-1:0]   in_last,
`endif
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_chan;
    logic          r_out_valid;
    logic [SW-1:0] r_ptr;

    logic          w_load;
    logic [N-1:0]  w_rr_gnt;
    logic [SW-1:0] w_rr_idx;
    logic          w_rr_any;
    logic [N-1:0]  w_gnt;
    logic [SW-1:0] w_gnt_idx;
    logic          w_gnt_any;
    logic [W-1:0]  w_sel_data;

`ifdef MUX_HOLD_EN
    logic          r_lock;
    logic          w_gnt_last;
`endif

    assign w_load = !r_out_valid || out_ready;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt     (w_rr_gnt),
        .gnt_idx (w_rr_idx),
        .gnt_any (w_rr_any)
    );

    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        if (mode == MODE_STATIC) begin
            // Out-of-range sel simply matches no channel.
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    w_gnt[i]  = 1'b1;
                    w_gnt_idx = SW'(i);
                    w_gnt_any = 1'b1;
                end
            end
`ifdef MUX_HOLD_EN
        end else if (r_lock) begin
            // Mid-packet: only the channel that owns the packet may proceed.
            for (int i = 0; i < N; i++) begin
                if (r_ptr == SW'(i) && in_valid[i]) begin
                    w_gnt[i]  = 1'b1;
                    w_gnt_idx = SW'(i);
                    w_gnt_any = 1'b1;
                end
            end
`endif
        end else begin
            w_gnt     = w_rr_gnt;
            w_gnt_idx = w_rr_idx;
            w_gnt_any = w_rr_any;
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = w_sel_data | in_data[i*W +: W];
            end
        end
    end

`ifdef MUX_HOLD_EN
    assign w_gnt_last = |(w_gnt & in_last);
`endif

    // Held low during reset so no producer sees a phantom accept.
    assign in_ready = (w_load && !rst) ? w_gnt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= SW'(N - 1);
`ifdef MUX_HOLD_EN
            r_lock      <= 1'b0;
`endif
        end else if (w_load) begin
            if (w_gnt_any) begin
                r_out_data  <= w_sel_data;
                r_out_chan  <= w_gnt_idx;
                r_out_valid <= 1'b1;
                if (mode == MODE_RR) begin
                    r_ptr  <= w_gnt_idx;
`ifdef MUX_HOLD_EN
                    r_lock <= !w_gnt_last;
`endif
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
